// File: rtl/tdc_pkg.sv
// Shared types and constants for the time-to-digital converter core.
// Hit entries hold {coarse, fine, intensity}; the FSM walks IDLE->MEAS->DRAIN->DONE.
package tdc_pkg;

  localparam int CNT_W    = 10;
  localparam int FINE_W   = 5;
  localparam int INT_W    = 5;
  localparam int MAX_HITS = 4;
  localparam int WINDOW   = 1023;
  localparam int DLL_W    = 32;
  localparam int SPAD_W   = 16;
  localparam int PTR_W    = 2;
  localparam int HCNT_W   = 3;
  localparam int DATA_W   = CNT_W + FINE_W;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MEAS,
    ST_DRAIN,
    ST_DONE
  } tdc_state_e;

  typedef struct packed {
    logic [CNT_W-1:0]  coarse;
    logic [FINE_W-1:0] fine;
    logic [INT_W-1:0]  intensity;
  } hit_entry_t;

  // Number of SPADs that fired; 16 fits in INT_W bits.
  function automatic logic [INT_W-1:0] popcount16(input logic [SPAD_W-1:0] mask);
    logic [INT_W-1:0] count;
    count = '0;
    for (int i = 0; i < SPAD_W; i++) begin
      count = count + INT_W'(mask[i]);
    end
    return count;
  endfunction

endpackage

// File: rtl/tdc_top_core_if.sv
// Hit readout stream: valid/ready beats carrying timestamp, intensity,
// burst size and last-beat flag. master = the TDC core, slave = readout logic.
interface tdc_top_core_if;
  import tdc_pkg::*;

  logic [DATA_W-1:0] TDC_Odata;
  logic [INT_W-1:0]  TDC_Oint;
  logic [PTR_W-1:0]  TDC_Onum;
  logic              TDC_Olast;
  logic              TDC_Ovalid;
  logic              TDC_Oready;

  modport master (
    output TDC_Odata,
    output TDC_Oint,
    output TDC_Onum,
    output TDC_Olast,
    output TDC_Ovalid,
    input  TDC_Oready
  );

  modport slave (
    input  TDC_Odata,
    input  TDC_Oint,
    input  TDC_Onum,
    input  TDC_Olast,
    input  TDC_Ovalid,
    output TDC_Oready
  );

endinterface

// File: rtl/tdc_fine_decode.sv
// Fine phase decoder: index of the 1->0 transition (wrapping) in the DLL tap
// snapshot; returns 0 when the snapshot holds no such transition.
module tdc_fine_decode
  import tdc_pkg::*;
(
  input  logic [DLL_W-1:0]  phase,
  output logic [FINE_W-1:0] fine
);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    fine = '0;
    // Descending scan so the lowest matching index wins on malformed snapshots.
    for (int i = DLL_W - 1; i >= 0; i--) begin
      if (phase[i] && !phase[(i + 1) % DLL_W]) begin
        fine = FINE_W'(i);
      end
    end
  end

endmodule

// File: rtl/tdc_top_core.sv
// TDC core: start edge opens a WINDOW-cycle measurement, up to MAX_HITS trigger
// edges are timestamped, then streamed out and TDC_INT pulses. Optional macro
// TDC_TGATE_EN makes TDC_tgate qualify hits; otherwise TDC_tgate is ignored.
module tdc_top_core
  import tdc_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst,
  input  logic [DLL_W-1:0]   DLL_Phase,
  input  logic               TDC_start,
  input  logic               TDC_trigger,
  input  logic [SPAD_W-1:0]  TDC_spaden,
  input  logic               TDC_tgate,
  output logic               TDC_INT,
  tdc_top_core_if.master     stream
);

  localparam logic [CNT_W-1:0]  COARSE_LAST = CNT_W'(WINDOW - 1);
  localparam logic [HCNT_W-1:0] HITS_FULL   = HCNT_W'(MAX_HITS);

  tdc_state_e        state, state_next;
  logic [CNT_W-1:0]  coarse;
  logic [HCNT_W-1:0] hit_cnt, hit_cnt_next;
  logic [PTR_W-1:0]  rd_ptr, last_idx;
  hit_entry_t        entries [MAX_HITS];
  hit_entry_t        new_entry, cur_entry;
  logic              start_d, trig_d;
  logic              start_edge, trig_edge, gate_ok, hit_take;
  logic              beat, is_last, drain;
  logic [FINE_W-1:0] fine;

  tdc_fine_decode u_fine (
    .phase (DLL_Phase),
    .fine  (fine)
  );

`ifdef TDC_TGATE_EN
  assign gate_ok = TDC_tgate;
`else
  logic unused_tgate;
  assign unused_tgate = TDC_tgate;
  assign gate_ok      = 1'b1;
`endif

  assign start_edge   = TDC_start & ~start_d;
  assign trig_edge    = TDC_trigger & ~trig_d;
  assign hit_take     = (state == ST_MEAS) && trig_edge && gate_ok && (hit_cnt < HITS_FULL);
  assign hit_cnt_next = hit_cnt + HCNT_W'(hit_take);
  assign new_entry    = '{coarse: coarse, fine: fine, intensity: popcount16(TDC_spaden)};

  assign drain     = (state == ST_DRAIN);
  assign last_idx  = PTR_W'(hit_cnt - HCNT_W'(1));
  assign is_last   = (rd_ptr == last_idx);
  assign beat      = drain && stream.TDC_Oready;
  assign cur_entry = entries[rd_ptr];

  // Payload is forced to zero whenever no beat is offered.
  assign stream.TDC_Ovalid = drain;
  assign stream.TDC_Odata  = drain ? {cur_entry.coarse, cur_entry.fine} : '0;
  assign stream.TDC_Oint   = drain ? cur_entry.intensity : '0;
  assign stream.TDC_Onum   = drain ? last_idx : '0;
  assign stream.TDC_Olast  = drain && is_last;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    TDC_INT    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start_edge) state_next = ST_MEAS;
      end
      ST_MEAS: begin
        // A hit on the overflow cycle is kept because hit_cnt_next includes it.
        if ((coarse == COARSE_LAST) || (hit_cnt_next == HITS_FULL)) begin
          state_next = (hit_cnt_next != '0) ? ST_DRAIN : ST_DONE;
        end
      end
      ST_DRAIN: begin
        if (beat && is_last) state_next = ST_DONE;
      end
      ST_DONE: begin
        TDC_INT    = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // NOTE: the four-entry hit buffer is reset along with the rest of the state,
  // which is cheap at this depth and keeps stale hits out of every burst.
  always_ff @(posedge clk_i or negedge rst) begin
    if (!rst) begin
      coarse  <= '0;
      hit_cnt <= '0;
      rd_ptr  <= '0;
      start_d <= 1'b0;
      trig_d  <= 1'b0;
      for (int i = 0; i < MAX_HITS; i++) begin
        entries[i] <= '0;
      end
    end else begin
      start_d <= TDC_start;
      trig_d  <= TDC_trigger;
      case (state)
        ST_IDLE: begin
          if (start_edge) coarse <= '0;
        end
        ST_MEAS: begin
          coarse <= coarse + CNT_W'(1);
          if (hit_take) begin
            entries[hit_cnt[PTR_W-1:0]] <= new_entry;
          end
          hit_cnt <= hit_cnt_next;
        end
        ST_DRAIN: begin
          if (beat && !is_last) rd_ptr <= rd_ptr + PTR_W'(1);
        end
        ST_DONE: begin
          hit_cnt <= '0;
          rd_ptr  <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tdc_top_core.sv
// Directed bench for tdc_top_core: single hit at overflow, four-hit early drain
// with backpressure, gating, no-hit window, late trigger and reset mid-drain.
module tb_tdc_top_core;
  import tdc_pkg::*;

  logic               clk_i = 1'b0;
  logic               rst;
  logic [DLL_W-1:0]   DLL_Phase;
  logic               TDC_start;
  logic               TDC_trigger;
  logic [SPAD_W-1:0]  TDC_spaden;
  logic               TDC_tgate;
  logic               TDC_INT;
  int                 checks   = 0;
  int                 failures = 0;
  int                 n;

  tdc_top_core_if bus ();

  tdc_top_core dut (
    .clk_i       (clk_i),
    .rst         (rst),
    .DLL_Phase   (DLL_Phase),
    .TDC_start   (TDC_start),
    .TDC_trigger (TDC_trigger),
    .TDC_spaden  (TDC_spaden),
    .TDC_tgate   (TDC_tgate),
    .TDC_INT     (TDC_INT),
    .stream      (bus)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Inputs change and outputs are sampled 1ns after the rising edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Start edge is consumed on the next edge; coarse is 0 afterwards.
  task automatic start_meas();
    TDC_start = 1'b1;
    tick();
    TDC_start = 1'b0;
  endtask

  // One trigger edge sampled at the current coarse value, then released (2 cycles).
  task automatic pulse(input logic [DLL_W-1:0] dll, input logic [SPAD_W-1:0] spad);
    DLL_Phase   = dll;
    TDC_spaden  = spad;
    TDC_trigger = 1'b1;
    tick();
    TDC_trigger = 1'b0;
    tick();
  endtask

  // Runs until the DUT offers a beat or pulses INT, with a cycle budget.
  task automatic wait_event(input int start_n, output int end_n);
    end_n = start_n;
    while (!(bus.TDC_Ovalid || TDC_INT) && end_n < 1100) begin
      tick();
      end_n++;
    end
  endtask

  task automatic check_beat(input string tag, input logic [31:0] data, input logic [31:0] intensity,
                            input logic [31:0] num, input logic [31:0] last);
    check({tag, "_valid"}, 32'(bus.TDC_Ovalid), 32'd1);
    check({tag, "_data"},  32'(bus.TDC_Odata),  data);
    check({tag, "_int"},   32'(bus.TDC_Oint),   intensity);
    check({tag, "_num"},   32'(bus.TDC_Onum),   num);
    check({tag, "_last"},  32'(bus.TDC_Olast),  last);
  endtask

  task automatic check_idle_out(input string tag);
    check({tag, "_valid"}, 32'(bus.TDC_Ovalid), 32'd0);
    check({tag, "_data"},  32'(bus.TDC_Odata),  32'd0);
    check({tag, "_int"},   32'(bus.TDC_Oint),   32'd0);
    check({tag, "_numlast"}, 32'({bus.TDC_Onum, bus.TDC_Olast}), 32'd0);
  endtask

  initial begin
    rst            = 1'b0;
    DLL_Phase      = 32'h0000_FFFF;
    TDC_start      = 1'b0;
    TDC_trigger    = 1'b0;
    TDC_spaden     = '0;
    TDC_tgate      = 1'b1;
    bus.TDC_Oready = 1'b1;
    repeat (3) tick();
    check_idle_out("reset");
    check("reset_irq", 32'(TDC_INT), 32'd0);
    rst = 1'b1;
    tick();
    check_idle_out("post_reset");

    // Basic hit at coarse 5, fine 15, one SPAD; drains after the full window.
    start_meas();
    repeat (5) tick();
    pulse(32'h0000_FFFF, 16'h0001);
    wait_event(7, n);
    check("basic_cycles", 32'(n), 32'd1023);
    check_beat("basic", 32'h0AF, 32'd1, 32'd0, 32'd1);
    check("basic_irq_low", 32'(TDC_INT), 32'd0);
    tick();
    check("basic_irq", 32'(TDC_INT), 32'd1);
    check_idle_out("basic_done");
    tick();
    check("basic_irq_once", 32'(TDC_INT), 32'd0);

    // Four hits at coarse 0,2,4,6 drain early; a fifth trigger is ignored.
    bus.TDC_Oready = 1'b0;
    start_meas();
    pulse(32'h0000_FFFF, 16'h0001);
    pulse(32'hFFFF_0000, 16'h00F1);
    pulse(32'h00FF_FF00, 16'h0FF1);
    pulse(32'hF000_0FFF, 16'h3FF1);
    pulse(32'h0000_FFFF, 16'h30F3);
    check_beat("four_b0", 32'h00F, 32'd1, 32'd3, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_beat("stall_b0", 32'h00F, 32'd1, 32'd3, 32'd0);
    end
    bus.TDC_Oready = 1'b1;
    tick();
    check_beat("four_b1", 32'h05F, 32'd5, 32'd3, 32'd0);
    bus.TDC_Oready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_beat("stall_b1", 32'h05F, 32'd5, 32'd3, 32'd0);
    end
    bus.TDC_Oready = 1'b1;
    tick();
    check_beat("four_b2", 32'h097, 32'd9, 32'd3, 32'd0);
    tick();
    check_beat("four_b3", 32'h0CB, 32'd11, 32'd3, 32'd1);
    tick();
    check("four_irq", 32'(TDC_INT), 32'd1);
    check_idle_out("four_done");
    tick();
    check("four_irq_once", 32'(TDC_INT), 32'd0);

    // Trigger with the gate low at coarse 0.
    TDC_tgate = 1'b0;
    start_meas();
    pulse(32'hFFFF_0000, 16'h000F);
    wait_event(2, n);
    check("gate_cycles", 32'(n), 32'd1023);
`ifdef TDC_TGATE_EN
    check("gate_irq", 32'(TDC_INT), 32'd1);
    check_idle_out("gate_blocked");
`else
    check_beat("gate_hit", 32'h01F, 32'd4, 32'd0, 32'd1);
    tick();
    check("gate_irq", 32'(TDC_INT), 32'd1);
`endif
    tick();
    TDC_tgate = 1'b1;

    // Empty window: no beat, INT after the last coarse cycle.
    start_meas();
    wait_event(0, n);
    check("nohit_cycles", 32'(n), 32'd1023);
    check("nohit_irq", 32'(TDC_INT), 32'd1);
    check_idle_out("nohit");
    tick();

    // Trigger after the window closed is dropped.
    pulse(32'h0000_FFFF, 16'h30F3);
    repeat (4) tick();
    check_idle_out("late");
    check("late_irq", 32'(TDC_INT), 32'd0);

    // Reset while draining aborts without INT; the next measurement is clean.
    bus.TDC_Oready = 1'b0;
    start_meas();
    repeat (4) pulse(32'h0000_FFFF, 16'h0003);
    check("rst_pre_valid", 32'(bus.TDC_Ovalid), 32'd1);
    rst = 1'b0;
    #1;
    check_idle_out("rst_async");
    check("rst_async_irq", 32'(TDC_INT), 32'd0);
    tick();
    check("rst_held_irq", 32'(TDC_INT), 32'd0);
    rst = 1'b1;
    bus.TDC_Oready = 1'b1;
    tick();
    start_meas();
    repeat (3) tick();
    pulse(32'h0000_FFFF, 16'hFFFF);
    wait_event(5, n);
    check("rst_new_cycles", 32'(n), 32'd1023);
    check_beat("rst_new", 32'h06F, 32'd16, 32'd0, 32'd1);
    tick();
    check("rst_new_irq", 32'(TDC_INT), 32'd1);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tdc_top_core.md
Name: tdc_top_core

Overview:
Single-clock time-to-digital converter core. A start pulse opens a measurement window and clears a coarse counter. Each gated SPAD trigger edge inside the window captures a timestamp (coarse count plus a fine DLL phase code) and an intensity (number of enabled SPADs). When the window closes, the captured hits are streamed out on a valid/ready interface and an interrupt is pulsed. It sits between the SPAD/analog front end and the core-logic readout.

Parameters:
CNT_W, 10, coarse counter width; TDC_Odata width = CNT_W+5
WINDOW, 1023, measurement window length in clk_i cycles (overflow point)
MAX_HITS, 4, hit buffer depth; fixed at 4 because TDC_Onum is 2 bits

Ports:
clk_i  in  1  logic clock; all logic is on the rising edge
rst  in  1  asynchronous, active-low reset
DLL_Phase  in  32  DLL tap snapshot: 16 contiguous ones and 16 zeros, rotating
TDC_start  in  1  measurement start, level; its rising edge is used
TDC_trigger  in  1  SPAD trigger, level; its rising edge is a hit candidate
TDC_spaden  in  16  4x4 SPAD fired mask
TDC_tgate  in  1  time gate; a hit is accepted only while high
TDC_Odata  out  15  {coarse[9:0], fine[4:0]}
TDC_Oint  out  5  popcount of TDC_spaden at hit time, range 0..16
TDC_Onum  out  2  total hits in the burst minus 1
TDC_Olast  out  1  final beat of the burst
TDC_Ovalid  out  1  stream valid
TDC_Oready  in  1  stream ready
TDC_INT  out  1  one-cycle pulse when a measurement completes

Behaviour:
- Reset clears the FSM to IDLE and zeroes the counter, pointers, buffer and edge registers. All outputs are 0 during and after reset. Reset asserted mid-operation aborts immediately; no INT is issued.
- Edge detection: start_d and trig_d are registered copies of the inputs. start_edge = TDC_start & ~start_d; trig_edge = TDC_trigger & ~trig_d.
- FSM states: IDLE, MEAS, DRAIN, DONE.
- IDLE: start_edge moves to MEAS; coarse = 0 in the first MEAS cycle and increments by 1 every MEAS cycle.
- MEAS, hit: trig_edge & TDC_tgate & (hit_cnt < 4) stores entry[hit_cnt] = {coarse, fine, popcount(spaden)}, then increments hit_cnt.
- Fine code: the index i (0..31) where DLL_Phase[i]=1 and DLL_Phase[(i+1) mod 32]=0, sampled in the hit cycle. If no such i exists, fine = 0.
- MEAS exit: when coarse == WINDOW-1 or the 4th hit is stored, go to DRAIN next cycle if hit_cnt > 0, else DONE. A hit in the same cycle as overflow is recorded.
- DRAIN: TDC_Ovalid = 1; data, int and last come from entry[rd_ptr]; TDC_Onum = hit_cnt-1.
  - The beat advances on Ovalid & Oready. Outputs hold stable while Oready is low.
  - TDC_Olast = (rd_ptr == hit_cnt-1). After the last handshake, go to DONE.
- DONE: TDC_INT = 1 for one cycle; clear hit_cnt and rd_ptr; return to IDLE.
- Ignored events: start_edge outside IDLE; triggers outside MEAS; triggers once 4 hits are stored.
- Ovalid is 0 outside DRAIN. Odata, Oint, Onum and Olast are 0 when Ovalid is 0.

Optional Feature:
TDC_TGATE_EN. When defined, a hit requires TDC_tgate=1. When undefined, TDC_tgate is ignored and every in-window trigger edge is a hit. The port exists in both builds.

Decomposition:
- Package tdc_pkg: CNT_W, FINE_W=5, INT_W=5, MAX_HITS, the state enum, and the hit entry struct {coarse, fine, int}.
- One sub-module, tdc_fine_decode: 32-bit DLL_Phase in, 5-bit transition index out, combinational.
- Popcount and FSM stay inline.

Test Plan:
- Basic hit: DLL_Phase=0x0000FFFF, start edge; trigger edge with tgate=1 and spaden=0x0001 when coarse=5; hold Oready=1 → after overflow, 1 beat: Odata=0x0AF, Oint=1, Onum=0, Olast=1; then INT pulses 1 cycle.
- Four hits: spaden=0x0001, 0x00F1, 0x0FF1, 0x3FF1 → Oint 1, 5, 9, 11; Onum=3 on all beats; Olast on the 4th beat only; drain starts without waiting for overflow; a 5th trigger is ignored.
- Backpressure: Oready=0 for 3 cycles mid-burst → Ovalid stays 1, Odata/Oint are unchanged, no beat is lost or duplicated.
- Gating: trigger edge with tgate=0 → no hit (with TDC_TGATE_EN); without the macro → hit recorded.
- No-hit and late triggers: start with no triggers → no Ovalid, INT pulses at coarse=1022+2 cycles; a trigger after overflow (spaden=0x30F3) → ignored, no output.
- Reset mid-DRAIN: rst low → Ovalid=0, INT=0, FSM in IDLE; a new start measures correctly.
